// File: rtl/button_filter.sv
// rtl/button_filter.sv - multi-channel synchroniser, debouncer and press-event generator
// Ticked debounce with rise/fall, long-press and auto-repeat pulses per channel.
module button_filter #(
  parameter int              CH       = 16,
  parameter int              TICK_DIV = 65536,
  parameter int              STABLE   = 4,
  parameter int              HOLD     = 250,
  parameter int              REPEAT   = 50,
  parameter logic [CH-1:0]   INIT     = {CH{1'b0}}
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CH-1:0] I,
  output logic [CH-1:0] O,
  output logic [CH-1:0] RISE,
  output logic [CH-1:0] FALL,
  output logic [CH-1:0] HOLD_P,
  output logic          TICK
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam int HW = $clog2(HOLD + 1);

  localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] ST_LAST  = SW'(STABLE - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HOLD - 1);
  localparam logic [HW-1:0] H_MAX    = HW'(HOLD);
  localparam logic [HW-1:0] H_RELOAD = (REPEAT > 0) ? HW'(HOLD - REPEAT) : HW'(HOLD);

  logic [PW-1:0] ps_cnt;
  logic          tick_en;
  logic [CH-1:0] sync_q1;
  logic [CH-1:0] sync_q2;
  logic [CH-1:0] o_nxt;
  logic [CH-1:0] rise_nxt;
  logic [CH-1:0] fall_nxt;
  logic [CH-1:0] hold_nxt;

  assign tick_en = (ps_cnt == PS_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ps_cnt <= '0;
      TICK   <= 1'b0;
    end else begin
      TICK   <= tick_en;
      ps_cnt <= tick_en ? '0 : ps_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [SW-1:0] stab_q;
    logic [SW-1:0] stab_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          differ;
    logic          accept;
    logic          o_d;
    logic          rise_d;
    logic          fall_d;
    logic          hold_p_d;

    assign differ = sync_q2[c] ^ O[c];
    assign accept = differ && (stab_q == ST_LAST);

    always_comb begin
      stab_d   = stab_q;
      hold_d   = hold_q;
      o_d      = O[c];
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      hold_p_d = 1'b0;
      if (tick_en) begin
        if (!differ) begin
          stab_d = '0;
        end else if (accept) begin
          stab_d = '0;
          o_d    = sync_q2[c];
          rise_d = sync_q2[c];
          fall_d = ~sync_q2[c];
        end else begin
          stab_d = stab_q + 1'b1;
        end

        // An accepted edge in either direction restarts the press timer and
        // suppresses any hold pulse due on the same tick.
        if (accept || !O[c]) begin
          hold_d = '0;
        end else if (hold_q == H_LAST) begin
          hold_p_d = 1'b1;
          hold_d   = H_RELOAD;
        end else if (hold_q == H_MAX) begin
          hold_d = hold_q;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        stab_q <= '0;
        hold_q <= '0;
      end else begin
        stab_q <= stab_d;
        hold_q <= hold_d;
      end
    end

    assign o_nxt[c]    = o_d;
    assign rise_nxt[c] = rise_d;
    assign fall_nxt[c] = fall_d;
    assign hold_nxt[c] = hold_p_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q1 <= INIT;
      sync_q2 <= INIT;
      O       <= INIT;
      RISE    <= '0;
      FALL    <= '0;
      HOLD_P  <= '0;
    end else begin
      sync_q1 <= I;
      sync_q2 <= sync_q1;
      O       <= o_nxt;
      RISE    <= rise_nxt;
      FALL    <= fall_nxt;
      HOLD_P  <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_button_filter.sv
// tb/tb_button_filter.sv - randomized bench for button_filter against a tick/press-time model
// Three instances: base parameters, fast variant without repeat, and INIT=1 on channel 0.
module tb_button_filter;

  localparam int          P_TD [3] = '{4, 1, 4};
  localparam int          P_ST [3] = '{3, 1, 3};
  localparam int          P_HD [3] = '{5, 5, 5};
  localparam int          P_RP [3] = '{2, 0, 2};
  localparam logic [3:0]  P_IN [3] = '{4'h0, 4'h0, 4'h1};

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] ib  [3];
  logic [3:0] o_v [3];
  logic [3:0] r_v [3];
  logic [3:0] f_v [3];
  logic [3:0] h_v [3];
  logic       t_v [3];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  button_filter #(.CH(4), .TICK_DIV(4), .STABLE(3), .HOLD(5), .REPEAT(2), .INIT(4'h0)) dut0 (
    .CLK(CLK), .RST(RST), .I(ib[0]), .O(o_v[0]), .RISE(r_v[0]), .FALL(f_v[0]),
    .HOLD_P(h_v[0]), .TICK(t_v[0]));
  button_filter #(.CH(4), .TICK_DIV(1), .STABLE(1), .HOLD(5), .REPEAT(0), .INIT(4'h0)) dut1 (
    .CLK(CLK), .RST(RST), .I(ib[1]), .O(o_v[1]), .RISE(r_v[1]), .FALL(f_v[1]),
    .HOLD_P(h_v[1]), .TICK(t_v[1]));
  button_filter #(.CH(4), .TICK_DIV(4), .STABLE(3), .HOLD(5), .REPEAT(2), .INIT(4'h1)) dut2 (
    .CLK(CLK), .RST(RST), .I(ib[2]), .O(o_v[2]), .RISE(r_v[2]), .FALL(f_v[2]),
    .HOLD_P(h_v[2]), .TICK(t_v[2]));

  // Model: I delayed two edges, ticks at every TICK_DIV-th edge since release,
  // run length of differing samples, and tick index of the last accepted rise.
  logic [3:0] m_hist [3][2];
  int         m_n    [3];
  int         m_k    [3];
  logic [3:0] m_o    [3];
  int         m_run  [3][4];
  int         m_rt   [3][4];
  logic [3:0] exp_o  [3];
  logic [3:0] exp_r  [3];
  logic [3:0] exp_f  [3];
  logic [3:0] exp_h  [3];
  logic       exp_t  [3];

  task automatic model_reset(input int d);
    m_hist[d][0] = P_IN[d];
    m_hist[d][1] = P_IN[d];
    m_n[d] = 0;
    m_k[d] = 0;
    m_o[d] = P_IN[d];
    for (int c = 0; c < 4; c++) begin
      m_run[d][c] = 0;
      m_rt[d][c]  = 0;
    end
    exp_o[d] = P_IN[d];
    exp_r[d] = 4'h0;
    exp_f[d] = 4'h0;
    exp_h[d] = 4'h0;
    exp_t[d] = 1'b0;
  endtask

  task automatic model_step(input int d, input logic [3:0] iv);
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] h;
    bit         tk;
    int         t;
    s = m_hist[d][1];
    m_hist[d][1] = m_hist[d][0];
    m_hist[d][0] = iv;
    m_n[d]++;
    tk = (m_n[d] % P_TD[d]) == 0;
    r = 4'h0;
    f = 4'h0;
    h = 4'h0;
    if (tk) begin
      m_k[d]++;
      for (int c = 0; c < 4; c++) begin
        if (s[c] != m_o[d][c]) begin
          m_run[d][c]++;
          if (m_run[d][c] == P_ST[d]) begin
            m_run[d][c] = 0;
            m_o[d][c]   = s[c];
            if (s[c]) begin
              r[c] = 1'b1;
              m_rt[d][c] = m_k[d];
            end else begin
              f[c] = 1'b1;
            end
          end
        end else begin
          m_run[d][c] = 0;
        end
        if (m_o[d][c] && !r[c]) begin
          t = m_k[d] - m_rt[d][c];
          if (P_RP[d] == 0) h[c] = (t == P_HD[d]);
          else h[c] = (t >= P_HD[d]) && (((t - P_HD[d]) % P_RP[d]) == 0);
        end
      end
    end
    exp_o[d] = m_o[d];
    exp_r[d] = r;
    exp_f[d] = f;
    exp_h[d] = h;
    exp_t[d] = tk;
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int d = 0; d < 3; d++) model_reset(d);
    end else begin
      for (int d = 0; d < 3; d++) model_step(d, ib[d]);
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({o_v[d], r_v[d], f_v[d], h_v[d], t_v[d]} !==
          {exp_o[d], exp_r[d], exp_f[d], exp_h[d], exp_t[d]}) begin
        failures++;
        if (failures <= 40)
          $display("FAIL model_cmp dut%0d t=%0t got O=%h R=%h F=%h H=%h T=%b exp O=%h R=%h F=%h H=%h T=%b",
                   d, $time, o_v[d], r_v[d], f_v[d], h_v[d], t_v[d],
                   exp_o[d], exp_r[d], exp_f[d], exp_h[d], exp_t[d]);
      end
    end
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    int n;
    int pdiv;
    int rst_left;
    for (int d = 0; d < 3; d++) ib[d] = 4'hF;
    RST = 1'b1;
    repeat (3) step();
    check("rst_O", o_v[0], 4'h0);
    check("rst_RISE", r_v[0], 4'h0);
    check("rst_FALL", f_v[0], 4'h0);
    check("rst_HOLD_P", h_v[0], 4'h0);
    check("rst_TICK", {3'b0, t_v[0]}, 4'h0);
    check("rst_O_init", o_v[2], 4'h1);

    RST   = 1'b0;
    ib[0] = 4'h0;
    ib[1] = 4'h0;
    ib[2] = 4'h1;
    for (int e = 1; e <= 52; e++) begin
      step();
      if (e <= 8) check("tick_phase", {3'b0, t_v[0]}, (e % 4 == 0) ? 4'h1 : 4'h0);
      case (e)
        15: check("press_O_before", o_v[0], 4'h0);
        16: begin
          check("press_O", o_v[0], 4'h1);
          check("press_RISE", r_v[0], 4'h1);
        end
        17: check("press_RISE_clear", r_v[0], 4'h0);
        19: check("init_hold_early", h_v[2], 4'h0);
        20: check("init_hold", h_v[2], 4'h1);
        35: check("hold_first_early", h_v[0], 4'h0);
        36: check("hold_first", h_v[0], 4'h1);
        40: check("hold_gap", h_v[0], 4'h0);
        42: check("fast_O_before", o_v[1], 4'h0);
        43: begin
          check("fast_O", o_v[1], 4'h5);
          check("fast_RISE", r_v[1], 4'h5);
        end
        44: check("hold_repeat", h_v[0], 4'h1);
        default: ;
      endcase
      if (e == 4) ib[0][0] = 1'b1;
      if (e == 40) ib[1] = 4'h5;
    end

    // Fall accepted on the tick where the first hold pulse would be due.
    ib[0][1] = 1'b1;
    n = 0;
    while (!r_v[0][1] && n < 60) begin
      step();
      n++;
    end
    check("coinc_rise_seen", {3'b0, r_v[0][1]}, 4'h1);
    repeat (8) step();
    ib[0][1] = 1'b0;
    repeat (12) step();
    check("coinc_FALL", {3'b0, f_v[0][1]}, 4'h1);
    check("coinc_HOLD_P", {3'b0, h_v[0][1]}, 4'h0);

    ib[0] = 4'h0;
    repeat (24) step();
    ib[0] = 4'hF;
    n = 0;
    while (r_v[0] == 4'h0 && n < 40) begin
      step();
      n++;
    end
    check("all_RISE", r_v[0], 4'hF);

    pdiv = 20;
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: pdiv = 3;
          1: pdiv = 8;
          2: pdiv = 30;
          default: pdiv = 90;
        endcase
      end
      for (int d = 0; d < 3; d++)
        for (int ch = 0; ch < 4; ch++)
          if ($urandom_range(0, pdiv - 1) == 0) ib[d][ch] = ~ib[d][ch];
      if (RST) begin
        if (rst_left == 0) RST = 1'b0;
        else rst_left--;
      end else if ($urandom_range(0, 599) == 0) begin
        RST = 1'b1;
        rst_left = 1;
      end
      step();
    end
    RST = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
